// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the traffic phase controller and its environment
// (timebase, mode/pedestrian requests, external phase counter, lamp drivers).
//   master : environment side - drives tick, night_mode, ped_req, cnt_last
//   slave  : controller side  - drives cnt_init, cnt_en, lamps, ped_walk, phase
interface traffic_phase_ctrl_if;
  logic       tick;
  logic       night_mode;
  logic       ped_req;
  logic       cnt_last;
  logic [2:0] cnt_init;
  logic       cnt_en;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       ped_walk;
  logic [2:0] phase;

  modport master (
    output tick, night_mode, ped_req, cnt_last,
    input  cnt_init, cnt_en, main_light, side_light, ped_walk, phase
  );

  modport slave (
    input  tick, night_mode, ped_req, cnt_last,
    output cnt_init, cnt_en, main_light, side_light, ped_walk, phase
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase controller with pedestrian walk and night flashing.
// Sequences MG -> MY -> SG -> SY -> MG, timing each phase with an external
// down-counter that it loads (cnt_init) and decrements (cnt_en).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : traffic_phase_ctrl_if.slave
//            in : tick, night_mode, ped_req, cnt_last
//            out: cnt_init (001 green load, 010 yellow load), cnt_en,
//                 main_light/side_light ({red,yellow,green}), ped_walk, phase
module traffic_phase_ctrl #(
  parameter int unsigned pTIME_GREEN_LIGHT  = 15,
  parameter int unsigned pTIME_YELLOW_LIGHT = 3,
  parameter int unsigned pCNT_WIDTH         = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_phase_ctrl_if.slave  bus
);

  // Load values live in the external counter; reject configurations it cannot hold.
  if ((pTIME_GREEN_LIGHT  >= (64'd1 << pCNT_WIDTH)) ||
      (pTIME_YELLOW_LIGHT >= (64'd1 << pCNT_WIDTH))) begin : g_bad_cfg
    $error("traffic_phase_ctrl: load value does not fit in pCNT_WIDTH");
  end

  typedef enum logic [2:0] {
    MG    = 3'd0,
    MY    = 3'd1,
    SG    = 3'd2,
    SY    = 3'd3,
    FLASH = 3'd4
  } state_e;

  localparam logic [2:0] INIT_NONE   = 3'b000;
  localparam logic [2:0] INIT_GREEN  = 3'b001;
  localparam logic [2:0] INIT_YELLOW = 3'b010;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_e     state_q, state_d;
  logic [2:0] init_q,  init_d;
  logic       blink_q, blink_d;
  logic       walk_q,  walk_d;
  logic       pend_q,  pend_d;
  logic       fire;

  // A load cycle never counts as expiry: cnt_last may still reflect the
  // previous phase's zero while the new value is being loaded.
  assign fire = bus.tick & bus.cnt_last & (init_q == INIT_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MG;
      init_q  <= INIT_NONE;
      blink_q <= 1'b0;
      walk_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      blink_q <= blink_d;
      walk_q  <= walk_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    init_d  = INIT_NONE;
    blink_d = blink_q;
    walk_d  = walk_q;
    pend_d  = pend_q | bus.ped_req;

    case (state_q)
      MG: begin
        if (fire) begin
          state_d = MY;
          init_d  = INIT_YELLOW;
        end
      end
      MY: begin
        if (fire) begin
          state_d = SG;
          init_d  = INIT_GREEN;
          // A request in this very cycle still makes this crossing.
          walk_d  = pend_q | bus.ped_req;
          pend_d  = 1'b0;
        end
      end
      SG: begin
        if (fire) begin
          state_d = SY;
          init_d  = INIT_YELLOW;
          walk_d  = 1'b0;
        end
      end
      SY: begin
        if (fire) begin
          if (bus.night_mode) begin
            state_d = FLASH;
            blink_d = 1'b0;
          end else begin
            state_d = MG;
            init_d  = INIT_GREEN;
          end
        end
      end
      FLASH: begin
        if (bus.tick) begin
          if (!bus.night_mode) begin
            state_d = MG;
            init_d  = INIT_GREEN;
            blink_d = 1'b0;
          end else begin
            blink_d = ~blink_q;
          end
        end
      end
      default: begin
        state_d = MG;
        init_d  = INIT_GREEN;
        blink_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.main_light = LAMP_RED;
    bus.side_light = LAMP_RED;
    case (state_q)
      MG: begin
        bus.main_light = LAMP_GREEN;
        bus.side_light = LAMP_RED;
      end
      MY: begin
        bus.main_light = LAMP_YELLOW;
        bus.side_light = LAMP_RED;
      end
      SG: begin
        bus.main_light = LAMP_RED;
        bus.side_light = LAMP_GREEN;
      end
      SY: begin
        bus.main_light = LAMP_RED;
        bus.side_light = LAMP_YELLOW;
      end
      FLASH: begin
        bus.main_light = {1'b0, blink_q, 1'b0};
        bus.side_light = {1'b0, blink_q, 1'b0};
      end
      default: begin
        bus.main_light = LAMP_RED;
        bus.side_light = LAMP_RED;
      end
    endcase
  end

  assign bus.cnt_en   = bus.tick & (init_q == INIT_NONE) & (state_q != FLASH) & ~bus.cnt_last;
  assign bus.cnt_init = init_q;
  assign bus.ped_walk = walk_q;
  assign bus.phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: external phase counter model, segment
// scoreboard (phase, duration, lamps, init pulse, walk) and directed
// reset / stalled-timebase / load-cycle checks.
module tb_traffic_phase_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic force_last;
  logic [4:0] cnt_q;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  traffic_phase_ctrl_if tb_if ();

  traffic_phase_ctrl #(
    .pTIME_GREEN_LIGHT  (15),
    .pTIME_YELLOW_LIGHT (3),
    .pCNT_WIDTH         (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tb_if.slave)
  );

  always #5 clk = ~clk;

  // External down-counter: resets to the green time, loads on cnt_init.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= 5'd15;
    else if (tb_if.cnt_init[0])  cnt_q <= 5'd15;
    else if (tb_if.cnt_init[1])  cnt_q <= 5'd3;
    else if (tb_if.cnt_en)       cnt_q <= cnt_q - 5'd1;
  end
  assign tb_if.cnt_last = force_last | (cnt_q == 5'd0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] ph;
    int         len;   // 0 = length not checked
    logic [2:0] ml;
    logic [2:0] sl;
    logic [2:0] ini;
    logic       w;
  } seg_t;

  seg_t sb_q[$];
  seg_t cur;
  bit   armed  = 1'b0;
  bit   in_seg = 1'b0;
  int   run    = 0;

  task automatic push_seg(input logic [2:0] ph, input int len, input logic [2:0] ml,
                          input logic [2:0] sl, input logic [2:0] ini, input logic w);
    seg_t s;
    s.ph = ph; s.len = len; s.ml = ml; s.sl = sl; s.ini = ini; s.w = w;
    sb_q.push_back(s);
  endtask

  // Segment monitor: a phase change closes the current segment (length check)
  // and pops the next expected one; lamps, walk and init checked every cycle.
  always @(negedge clk) begin
    if (armed) begin
      if (!in_seg || tb_if.phase != cur.ph) begin
        if (in_seg && cur.len != 0) check_eq("seg_len", run, cur.len);
        if (sb_q.size() == 0) begin
          check_eq("sb_empty", sb_q.size(), 1);
          in_seg = 1'b0;
        end else begin
          cur    = sb_q.pop_front();
          in_seg = 1'b1;
          run    = 0;
          check_eq("seg_phase", tb_if.phase, cur.ph);
        end
      end
      if (in_seg) begin
        if (cur.ph == 3'd4) begin
          check_eq("flash_main", tb_if.main_light, run[0] ? 3'b010 : 3'b000);
          check_eq("flash_side", tb_if.side_light, run[0] ? 3'b010 : 3'b000);
        end else begin
          check_eq("main_light", tb_if.main_light, cur.ml);
          check_eq("side_light", tb_if.side_light, cur.sl);
        end
        check_eq("cnt_init", tb_if.cnt_init, (run == 0) ? cur.ini : 3'b000);
        check_eq("ped_walk", tb_if.ped_walk, cur.w);
        run++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && tb_if.phase != 3'd4)
      assert (!((|tb_if.main_light[1:0]) && (|tb_if.side_light[1:0])))
        else $error("both roads non-red: main=%b side=%b", tb_if.main_light, tb_if.side_light);
  end

  task automatic wait_phase(input logic [2:0] ph, input int max_cyc);
    int k = 0;
    while (tb_if.phase != ph && k < max_cyc) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("wait_phase", tb_if.phase, ph);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    force_last       = 1'b0;
    tb_if.tick       = 1'b1;
    tb_if.night_mode = 1'b0;
    tb_if.ped_req    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_phase", tb_if.phase, 3'd0);
    check_eq("rst_main",  tb_if.main_light, 3'b001);
    check_eq("rst_side",  tb_if.side_light, 3'b100);
    check_eq("rst_init",  tb_if.cnt_init, 3'b000);
    check_eq("rst_walk",  tb_if.ped_walk, 1'b0);

    // Full cycle with ped request, then night flash and recovery.
    push_seg(3'd0, 16, 3'b001, 3'b100, 3'b000, 1'b0);
    push_seg(3'd1,  5, 3'b010, 3'b100, 3'b010, 1'b0);
    push_seg(3'd2, 17, 3'b100, 3'b001, 3'b001, 1'b1);
    push_seg(3'd3,  5, 3'b100, 3'b010, 3'b010, 1'b0);
    push_seg(3'd0, 17, 3'b001, 3'b100, 3'b001, 1'b0);
    push_seg(3'd1,  5, 3'b010, 3'b100, 3'b010, 1'b0);
    push_seg(3'd2, 17, 3'b100, 3'b001, 3'b001, 1'b0);
    push_seg(3'd3,  5, 3'b100, 3'b010, 3'b010, 1'b0);
    push_seg(3'd4,  9, 3'b000, 3'b000, 3'b000, 1'b0);
    push_seg(3'd0, 17, 3'b001, 3'b100, 3'b001, 1'b0);
    push_seg(3'd1,  5, 3'b010, 3'b100, 3'b010, 1'b0);
    push_seg(3'd2,  0, 3'b100, 3'b001, 3'b001, 1'b1);

    rst_n = 1'b1;
    armed = 1'b1;

    repeat (3) @(posedge clk);
    #1 tb_if.ped_req = 1'b1;
    @(posedge clk);
    #1 tb_if.ped_req = 1'b0;

    wait_phase(3'd2, 60);
    wait_phase(3'd3, 60);
    wait_phase(3'd2, 60);
    tb_if.night_mode = 1'b1;        // ignored until SY expires
    repeat (4) @(posedge clk);
    #1 tb_if.ped_req = 1'b1;        // walk latched at MY->SG, so this waits for next SG
    @(posedge clk);
    #1 tb_if.ped_req = 1'b0;

    wait_phase(3'd4, 60);
    repeat (8) @(posedge clk);
    #1 tb_if.night_mode = 1'b0;

    for (int k = 0; k < 200 && sb_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check_eq("sb_drain", sb_q.size(), 0);
    armed = 1'b0;

    // Asynchronous reset in SY, checked before the next clock edge.
    wait_phase(3'd3, 60);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_phase", tb_if.phase, 3'd0);
    check_eq("async_main",  tb_if.main_light, 3'b001);
    check_eq("async_side",  tb_if.side_light, 3'b100);
    check_eq("async_init",  tb_if.cnt_init, 3'b000);
    check_eq("async_walk",  tb_if.ped_walk, 1'b0);

    // Stalled timebase: no tick, cnt_last forced high, nothing may move.
    tb_if.tick = 1'b0;
    force_last = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check_eq("stall_phase", tb_if.phase, 3'd0);
      check_eq("stall_en",    tb_if.cnt_en, 1'b0);
      check_eq("stall_init",  tb_if.cnt_init, 3'b000);
    end

    // First tick fires immediately; the following load cycle must not.
    @(posedge clk);
    #1 tb_if.tick = 1'b1;
    @(posedge clk); #1;
    check_eq("tick_fire_phase", tb_if.phase, 3'd1);
    check_eq("tick_fire_init",  tb_if.cnt_init, 3'b010);
    @(posedge clk); #1;
    check_eq("load_nofire_phase", tb_if.phase, 3'd1);
    check_eq("load_nofire_init",  tb_if.cnt_init, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 The module SHALL have parameter pTIME_GREEN_LIGHT, default 15, giving the green load value for both roads.
REQ-002 The module SHALL have parameter pTIME_YELLOW_LIGHT, default 3, giving the yellow load value for both roads.
REQ-003 The module SHALL have parameter pCNT_WIDTH, default 5, giving the counter width; cnt_out is not consumed.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  one-cycle timebase strobe, one per second.
REQ-007 night_mode  input  1  level request for flashing-yellow operation.
REQ-008 ped_req  input  1  pedestrian button, single-cycle pulse or level.
REQ-009 cnt_last  input  1  phase counter reached 0.
REQ-010 cnt_init  output  3  one-hot load command to the counter; bit0 green, bit1 yellow, bit2 red (unused, always 0).
REQ-011 cnt_en  output  1  counter decrement enable.
REQ-012 main_light  output  3  main road lamps; bit2 red, bit1 yellow, bit0 green.
REQ-013 side_light  output  3  side road lamps, same encoding.
REQ-014 ped_walk  output  1  pedestrian walk lamp for crossing the main road.
REQ-015 phase  output  3  current state: 0 MG, 1 MY, 2 SG, 3 SY, 4 FLASH.

Function
REQ-016 The FSM SHALL have states MG (main green), MY (main yellow), SG (side green), SY (side yellow) and FLASH; codes 5-7 SHALL recover to MG with cnt_init=001.
REQ-017 A timed transition SHALL fire on a cycle where tick=1, cnt_last=1 and cnt_init=000; a cycle with any cnt_init bit set SHALL never fire one.
REQ-018 The timed order SHALL be MG->MY->SG->SY->MG; from SY, night_mode=1 in the firing cycle SHALL select FLASH instead of MG.
REQ-019 On entry to MG or SG, cnt_init SHALL be 001 for exactly the following cycle; on entry to MY or SY it SHALL be 010; on entry to FLASH it SHALL stay 000.
REQ-020 cnt_en SHALL be combinational: tick AND (cnt_init==000) AND (phase!=FLASH) AND NOT cnt_last.
REQ-021 Each timed phase SHALL last load_value+1 ticks plus one cycle: MG/SG 16 ticks, MY/SY 4 ticks.
REQ-022 Lamps SHALL be: MG main=001, side=100; MY main=010, side=100; SG main=100, side=001; SY main=100, side=010.
REQ-023 No state SHALL ever drive green or yellow on both roads simultaneously, except FLASH.
REQ-024 In FLASH, both roads SHALL show {0,blink,0}; blink SHALL be cleared on entry and SHALL toggle on every tick.
REQ-025 In FLASH, a tick with night_mode=0 SHALL move to MG with cnt_init=001 next cycle and blink cleared.
REQ-026 A ped_req seen high in any cycle SHALL set a sticky ped_pending flag.
REQ-027 On the MY->SG transition, ped_walk SHALL be set if ped_pending=1 (including a ped_req in that same cycle), and ped_pending SHALL be cleared.
REQ-028 ped_walk SHALL clear on the SG->SY transition.
REQ-029 A ped_req arriving during SG with ped_walk=0 SHALL stay pending for the next SG.
REQ-030 night_mode SHALL be ignored in all states except the SY firing cycle and FLASH.

Reset
REQ-031 Asserting rst_n low SHALL immediately set phase=MG, main_light=001, side_light=100, cnt_init=000, ped_walk=0, ped_pending=0 and blink=0.
REQ-032 Reset mid-phase SHALL abandon the phase with no init pulse issued; the counter relies on its own reset to load the green time.

Verification
REQ-033 The bench SHALL cover: reset release, tick every cycle, counter model at 15 -> MG for 16 ticks, then phase=1 and cnt_init=010 for one cycle, then MY for 4 ticks, then SG.
REQ-034 The bench SHALL cover: a ped_req pulse during MG -> ped_walk=1 throughout the next SG, 0 in SY; the following SG has ped_walk=0.
REQ-035 The bench SHALL cover: night_mode=1 raised during SG -> SY completes, then phase=4; lamps 000 and 010 alternate per tick on both roads; night_mode=0 -> MG with cnt_init=001.
REQ-036 The bench SHALL cover: tick held low 100 cycles in MG with cnt_last=1 -> phase and cnt_en unchanged and cnt_init=000.
REQ-037 The bench SHALL cover: rst_n pulsed low during SY -> asynchronous return to MG, main=001 and side=100 before the next clk edge.
REQ-038 The bench SHALL check, via an assertion across all runs, that main and side lamps are never both non-red outside FLASH.
